// File: rtl/riscv_core_bp_pkg.sv
// Shared types for the branch-redirect controller and its predictor-update FIFO.
//   redir_state_e : controller FSM states (IDLE / REDIRECT)
//   bp_upd_rec_t  : one predictor-update record {pc, target, taken}
// Record address fields are sized for the widest supported address; narrower
// instances zero-extend on entry and truncate on exit.
package riscv_core_bp_pkg;

  localparam int unsigned BP_ALEN_MAX = 64;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } redir_state_e;

  typedef struct packed {
    logic [BP_ALEN_MAX-1:0] pc;
    logic [BP_ALEN_MAX-1:0] target;
    logic                   taken;
  } bp_upd_rec_t;

  function automatic bp_upd_rec_t mk_upd_rec(input logic [BP_ALEN_MAX-1:0] pc,
                                             input logic [BP_ALEN_MAX-1:0] target,
                                             input logic                   taken);
    bp_upd_rec_t rec;
    rec.pc     = pc;
    rec.target = target;
    rec.taken  = taken;
    return rec;
  endfunction

endpackage

// File: rtl/riscv_core_redirect_ctrl_if.sv
// Fetch-redirect and predictor-update channels of the redirect controller.
//   o_redirect_valid / o_redirect_pc / i_fetch_ready : redirect request to fetch
//   o_bp_upd_valid / _pc / _target / _taken / i_bp_upd_ready : predictor update
// master = redirect controller, slave = fetch unit / branch predictor.
interface riscv_core_redirect_ctrl_if #(
  parameter int unsigned ALEN = 64
);
  logic            o_redirect_valid;
  logic [ALEN-1:0] o_redirect_pc;
  logic            i_fetch_ready;

  logic            o_bp_upd_valid;
  logic [ALEN-1:0] o_bp_upd_pc;
  logic [ALEN-1:0] o_bp_upd_target;
  logic            o_bp_upd_taken;
  logic            i_bp_upd_ready;

  modport master (
    output o_redirect_valid, o_redirect_pc,
    output o_bp_upd_valid, o_bp_upd_pc, o_bp_upd_target, o_bp_upd_taken,
    input  i_fetch_ready, i_bp_upd_ready
  );

  modport slave (
    input  o_redirect_valid, o_redirect_pc,
    input  o_bp_upd_valid, o_bp_upd_pc, o_bp_upd_target, o_bp_upd_taken,
    output i_fetch_ready, i_bp_upd_ready
  );
endinterface

// File: rtl/riscv_core_bp_upd_fifo.sv
// Predictor-update FIFO, UPD_DEPTH entries (power of two, >= 2).
//   i_push / i_push_rec : enqueue (ignored when full)
//   i_pop               : dequeue head (ignored when empty)
//   o_head              : head record, all-zero while empty
//   o_full / o_empty    : occupancy flags
// No push-to-head bypass: a record pushed into an empty FIFO is visible next cycle.
module riscv_core_bp_upd_fifo
  import riscv_core_bp_pkg::*;
#(
  parameter int unsigned ALEN      = 64,
  parameter int unsigned UPD_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  bp_upd_rec_t i_push_rec,
  input  logic        i_pop,
  output bp_upd_rec_t o_head,
  output logic        o_full,
  output logic        o_empty
);
  localparam int unsigned AW = $clog2(UPD_DEPTH);
  localparam int unsigned RW = 2 * ALEN + 1;

  logic [RW-1:0] r_mem [UPD_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;
  logic [RW-1:0] w_head_raw;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign w_head_raw = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {i_push_rec.pc[ALEN-1:0], i_push_rec.target[ALEN-1:0],
                                  i_push_rec.taken};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  always_comb begin
    o_head = '0;
    if (!o_empty) begin
      o_head.pc     = BP_ALEN_MAX'(w_head_raw[RW-1 -: ALEN]);
      o_head.target = BP_ALEN_MAX'(w_head_raw[ALEN:1]);
      o_head.taken  = w_head_raw[0];
    end
  end

endmodule

// File: rtl/riscv_core_redirect_ctrl.sv
// Branch/jump resolution controller.
//   EX inputs (i_ex_*, i_is_taken, i_mis_prediction, i_recovery_address)
//   io_fe_bp         : redirect request to fetch and predictor-update record stream
//   o_flush          : one-cycle IF/ID + ID/EX flush on entering REDIRECT
//   o_ex_stall       : EX holds a control-flow instruction while the update FIFO is full
//   o_mispredict_cnt : accepted mispredictions (wrapping)
// Every accepted resolution is queued for the predictor; a mispredicted one also
// starts a redirect that is held until fetch accepts it. EX is ignored meanwhile.
module riscv_core_redirect_ctrl
  import riscv_core_bp_pkg::*;
#(
  parameter int unsigned ALEN      = 64,
  parameter int unsigned UPD_DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_ex_valid,
  input  logic                        i_ex_branch,
  input  logic                        i_ex_jump,
  input  logic [ALEN-1:0]             i_ex_pc,
  input  logic [ALEN-1:0]             i_ex_target,
  input  logic                        i_is_taken,
  input  logic                        i_mis_prediction,
  input  logic [ALEN-1:0]             i_recovery_address,
  riscv_core_redirect_ctrl_if.master  io_fe_bp,
  output logic                        o_flush,
  output logic                        o_ex_stall,
  output logic [31:0]                 o_mispredict_cnt
);
  redir_state_e    r_state;
  redir_state_e    w_state_nxt;
  logic            r_flush;
  logic [ALEN-1:0] r_redirect_pc;
  logic [31:0]     r_mispredict_cnt;

  logic            w_is_cf;
  logic            w_idle;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_take_redirect;
  bp_upd_rec_t     w_push_rec;
  bp_upd_rec_t     w_head;

  assign w_is_cf         = i_ex_valid & (i_ex_branch | i_ex_jump);
  assign w_idle          = (r_state == ST_IDLE);
  assign w_accept        = w_idle & w_is_cf & ~w_full;
  assign w_take_redirect = w_accept & i_mis_prediction;
  assign o_ex_stall      = w_idle & w_is_cf & w_full;

  assign w_push_rec = mk_upd_rec(BP_ALEN_MAX'(i_ex_pc), BP_ALEN_MAX'(i_ex_target), i_is_taken);

  riscv_core_bp_upd_fifo #(
    .ALEN      (ALEN),
    .UPD_DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_accept),
    .i_push_rec (w_push_rec),
    .i_pop      (~w_empty & io_fe_bp.i_bp_upd_ready),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign io_fe_bp.o_bp_upd_valid  = ~w_empty;
  assign io_fe_bp.o_bp_upd_pc     = w_head.pc[ALEN-1:0];
  assign io_fe_bp.o_bp_upd_target = w_head.target[ALEN-1:0];
  assign io_fe_bp.o_bp_upd_taken  = w_head.taken;

  always_comb begin
    w_state_nxt               = r_state;
    io_fe_bp.o_redirect_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_take_redirect) w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        io_fe_bp.o_redirect_valid = 1'b1;
        if (io_fe_bp.i_fetch_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Flush is registered from the entry condition, so it is high only in the
  // first REDIRECT cycle regardless of how long fetch takes to accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= ST_IDLE;
      r_flush          <= 1'b0;
      r_redirect_pc    <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_take_redirect;
      if (w_take_redirect) begin
        r_redirect_pc    <= i_recovery_address;
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
    end
  end

  assign o_flush                 = r_flush;
  assign io_fe_bp.o_redirect_pc  = r_redirect_pc;
  assign o_mispredict_cnt        = r_mispredict_cnt;

endmodule

// File: tb/tb_riscv_core_redirect_ctrl.sv
module tb_riscv_core_redirect_ctrl;
  localparam int unsigned ALEN  = 64;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ex_branch, ex_jump, is_taken, mis, fetch_ready, upd_ready;
  logic [ALEN-1:0] ex_pc, ex_target, rec_addr;
  logic            flush, ex_stall;
  logic [31:0]     mis_cnt;

  always #5 clk = ~clk;

  riscv_core_redirect_ctrl_if #(.ALEN(ALEN)) bus ();
  assign bus.i_fetch_ready  = fetch_ready;
  assign bus.i_bp_upd_ready = upd_ready;

  riscv_core_redirect_ctrl #(.ALEN(ALEN), .UPD_DEPTH(DEPTH)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_ex_valid         (ex_valid),
    .i_ex_branch        (ex_branch),
    .i_ex_jump          (ex_jump),
    .i_ex_pc            (ex_pc),
    .i_ex_target        (ex_target),
    .i_is_taken         (is_taken),
    .i_mis_prediction   (mis),
    .i_recovery_address (rec_addr),
    .io_fe_bp           (bus),
    .o_flush            (flush),
    .o_ex_stall         (ex_stall),
    .o_mispredict_cnt   (mis_cnt)
  );

  // Reference model: queue of pending predictor records plus redirect bookkeeping.
  typedef struct {
    logic [63:0] pc;
    logic [63:0] tg;
    logic        tk;
  } rec_t;
  rec_t        q[$];
  bit          m_redir, m_first;
  logic [63:0] m_rpc;
  logic [31:0] m_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_redir = 0;
    m_first = 0;
    m_rpc   = '0;
    m_cnt   = '0;
  endtask

  task automatic check_all();
    bit   cf;
    rec_t h;
    cf = ex_valid && (ex_branch || ex_jump);
    h  = '{pc: '0, tg: '0, tk: 1'b0};
    if (q.size() > 0) h = q[0];
    chk("flush",      64'(flush),                m_first);
    chk("redir_vld",  64'(bus.o_redirect_valid), m_redir);
    chk("redir_pc",   bus.o_redirect_pc,         m_rpc);
    chk("cnt",        64'(mis_cnt),              64'(m_cnt));
    chk("upd_vld",    64'(bus.o_bp_upd_valid),   64'(q.size() > 0));
    chk("upd_pc",     bus.o_bp_upd_pc,           h.pc);
    chk("upd_tgt",    bus.o_bp_upd_target,       h.tg);
    chk("upd_tk",     64'(bus.o_bp_upd_taken),   64'(h.tk));
    chk("ex_stall",   64'(ex_stall),             64'(!m_redir && cf && q.size() == DEPTH));
  endtask

  task automatic model_step();
    int sz;
    bit acc;
    sz  = q.size();
    acc = !m_redir && ex_valid && (ex_branch || ex_jump) && sz < DEPTH;
    if (sz > 0 && upd_ready) void'(q.pop_front());
    if (acc) q.push_back('{pc: ex_pc, tg: ex_target, tk: is_taken});
    if (m_redir) begin
      m_first = 0;
      if (fetch_ready) m_redir = 0;
    end else if (acc && mis) begin
      m_redir = 1;
      m_first = 1;
      m_rpc   = rec_addr;
      m_cnt   = m_cnt + 32'd1;
    end
  endtask

  // Inputs are stable from posedge+1; check mid-cycle, then advance model and DUT.
  task automatic tick();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic j, input logic [63:0] pc,
                       input logic [63:0] tg, input logic tk, input logic m,
                       input logic [63:0] ra);
    ex_valid = v; ex_branch = br; ex_jump = j; ex_pc = pc;
    ex_target = tg; is_taken = tk; mis = m; rec_addr = ra;
  endtask

  task automatic idle_ex();
    drive(0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_ready = 1'b1;
    upd_ready = 1'b1;
    idle_ex();
    model_reset();
    #3;
    check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Correctly predicted taken branch: record visible next cycle, no flush.
    drive(1, 1, 0, 64'h1000, 64'h1040, 1, 0, '0);
    tick();
    chk("t036_vld", 64'(bus.o_bp_upd_valid), 1);
    chk("t036_pc",  bus.o_bp_upd_pc, 64'h1000);
    chk("t036_tgt", bus.o_bp_upd_target, 64'h1040);
    chk("t036_tk",  64'(bus.o_bp_upd_taken), 1);
    chk("t036_fl",  64'(flush), 0);
    idle_ex();
    tick();

    // Mispredict with fetch ready: flush + redirect at N+1, IDLE at N+2.
    drive(1, 1, 0, 64'h1100, 64'h1200, 1, 1, 64'h2000);
    tick();
    idle_ex();
    chk("t037_fl",  64'(flush), 1);
    chk("t037_pc",  bus.o_redirect_pc, 64'h2000);
    chk("t037_cnt", 64'(mis_cnt), 1);
    tick();
    chk("t037_idle", 64'(bus.o_redirect_valid), 0);

    // Mispredict with fetch stalled 3 cycles; wrong-path EX traffic ignored.
    fetch_ready = 1'b0;
    drive(0, 0, 1, 64'h1300, 64'h3000, 1, 1, 64'h3000);
    drive(1, 0, 1, 64'h1300, 64'h3000, 1, 1, 64'h3000);
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1, 1, 0, 64'h5000 + 64'(i), 64'h6000, 0, 1, 64'h7000);
      tick();
    end
    fetch_ready = 1'b1;
    tick();
    idle_ex();
    chk("t038_vld", 64'(bus.o_redirect_valid), 0);
    chk("t038_cnt", 64'(mis_cnt), 2);
    chk("t038_pc",  bus.o_redirect_pc, 64'h3000);
    repeat (2) tick();

    // Predictor port stalled: two fill the FIFO, third stalls until a pop.
    upd_ready = 1'b0;
    drive(1, 1, 0, 64'hA00, 64'hA40, 0, 0, '0); tick();
    drive(1, 0, 1, 64'hB00, 64'hB80, 1, 0, '0); tick();
    drive(1, 1, 0, 64'hC00, 64'hC40, 1, 0, '0);
    chk("t039_stall", 64'(ex_stall), 1);
    tick(); tick();
    upd_ready = 1'b1;
    tick();
    chk("t039_go", 64'(ex_stall), 0);
    tick();
    idle_ex();
    repeat (3) tick();

    // Reset while redirecting with two queued records.
    upd_ready = 1'b0;
    fetch_ready = 1'b0;
    drive(1, 1, 0, 64'hD00, 64'hD40, 0, 0, '0); tick();
    drive(1, 1, 0, 64'hE00, 64'hE40, 1, 1, 64'h4000); tick();
    idle_ex();
    chk("t040_pre", 64'(bus.o_redirect_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t040_rv",  64'(bus.o_redirect_valid), 0);
    chk("t040_uv",  64'(bus.o_bp_upd_valid), 0);
    chk("t040_cnt", 64'(mis_cnt), 0);
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    fetch_ready = 1'b1;
    upd_ready = 1'b1;
    tick();
    chk("t040_empty", 64'(bus.o_bp_upd_valid), 0);

    // Randomized traffic.
    for (int unsigned i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, {$urandom, $urandom});
      fetch_ready = $urandom_range(0, 2) != 0;
      upd_ready   = $urandom_range(0, 2) == 0;
      tick();
    end
    idle_ex();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_redirect_ctrl.md
RISCV_CORE_REDIRECT_CTRL -- requirements
Module: riscv_core_redirect_ctrl

Interface
REQ-001 Parameter ALEN, default 64, address width.
REQ-002 Parameter UPD_DEPTH, default 2, predictor-update FIFO depth (power of two, >=2).
REQ-003 i_clk  input  1  core clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_ex_valid  input  1  EX holds a resolved instruction this cycle.
REQ-006 i_ex_branch / i_ex_jump  input  1 each  EX instruction is conditional branch / jump.
REQ-007 i_ex_pc  input  ALEN  PC of EX instruction.
REQ-008 i_ex_target  input  ALEN  resolved target address.
REQ-009 i_is_taken  input  1  branch-unit taken result (1 for jumps).
REQ-010 i_mis_prediction  input  1  misprediction flag from recovery unit.
REQ-011 i_recovery_address  input  ALEN  correct fetch address on misprediction.
REQ-012 i_fetch_ready  input  1  fetch accepts redirect.
REQ-013 i_bp_upd_ready  input  1  predictor update port accepts record.
REQ-014 o_flush  output  1  one-cycle flush of IF/ID and ID/EX.
REQ-015 o_redirect_valid / o_redirect_pc  output  1 / ALEN  redirect request and address.
REQ-016 o_bp_upd_valid, o_bp_upd_pc, o_bp_upd_target, o_bp_upd_taken  output  1/ALEN/ALEN/1  predictor update record.
REQ-017 o_ex_stall  output  1  EX must hold its instruction.
REQ-018 o_mispredict_cnt  output  32  count of accepted mispredictions.

Function
REQ-019 Resolution "accepted" when state IDLE, i_ex_valid, (i_ex_branch|i_ex_jump), and FIFO not full.
REQ-020 o_ex_stall = i_ex_valid & (i_ex_branch|i_ex_jump) & FIFO full & state IDLE; combinational.
REQ-021 Every accepted resolution pushes {i_ex_pc, i_ex_target, i_is_taken} into the update FIFO in the same edge.
REQ-022 FIFO head drives o_bp_upd_*; o_bp_upd_valid = FIFO not empty; pop on valid & i_bp_upd_ready.
REQ-023 Simultaneous push and pop when full is not allowed (push blocked by full); when empty, push appears at head next cycle (no bypass).
REQ-024 FSM states IDLE, REDIRECT.
REQ-025 IDLE -> REDIRECT when accepted resolution has i_mis_prediction=1; capture i_recovery_address into o_redirect_pc; increment o_mispredict_cnt (wraps at 2^32-1 -> 0).
REQ-026 o_flush = 1 for exactly the first cycle in REDIRECT (cycle N+1 after mispredict at N); 0 otherwise.
REQ-027 In REDIRECT o_redirect_valid = 1, o_redirect_pc stable until i_fetch_ready=1; then REDIRECT -> IDLE next edge.
REQ-028 In REDIRECT, EX inputs are ignored (wrong path): no push, no count, o_ex_stall=0.
REQ-029 i_mis_prediction with i_ex_valid=0 or neither branch nor jump is ignored.
REQ-030 FIFO draining continues independently of FSM state.
REQ-031 Minimum mispredict-to-IDLE latency 2 cycles (ready at N+1, IDLE at N+2).

Reset
REQ-032 On i_rst_n low, asynchronously: state IDLE, FIFO empty, o_flush=0, o_redirect_valid=0, o_redirect_pc=0, o_bp_upd_valid=0, o_mispredict_cnt=0; o_bp_upd_pc/target/taken=0.
REQ-033 Reset asserted mid-REDIRECT or with FIFO occupied discards the redirect and all queued records.

Structure
REQ-034 State enum and update-record struct live in shared package riscv_core_bp_pkg.
REQ-035 Update FIFO is sub-module riscv_core_bp_upd_fifo (parameters ALEN, UPD_DEPTH).

Verification
REQ-036 Correct branch at 0x1000, i_is_taken=1, target 0x1040, port ready -> o_bp_upd_valid next cycle with {0x1000,0x1040,1}; o_flush=0.
REQ-037 Mispredict at N, recovery 0x2000, i_fetch_ready=1 -> o_flush=1 and o_redirect_pc=0x2000 at N+1, IDLE at N+2, counter=1.
REQ-038 Mispredict with i_fetch_ready low 3 cycles -> o_redirect_valid held 4 cycles, o_flush only first cycle, EX valid ignored throughout.
REQ-039 i_bp_upd_ready=0, three resolutions back-to-back -> two pushed, third sees o_ex_stall=1 until ready rises, then accepted.
REQ-040 Reset pulse in REDIRECT with 2 queued records -> all outputs 0 immediately, FIFO empty after release.
